// File: rtl/wb_statis_roi_pkg.sv
// Shared constants and width rules for the white-balance ROI statistics block.
package wb_statis_roi_pkg;

    localparam int NUM_CH  = 3;   // channel index: 0 = R, 1 = G, 2 = B
    localparam int CH_G    = 1;
    localparam int SLICE_W = 8;

    // Largest legal slice offset: the 8-bit slice must stay inside the pixel.
    function automatic int max_shift(input int dat_w);
        return dat_w - SLICE_W;
    endfunction

    // ROI compares carry one extra bit so offset+size never wraps.
    function automatic int roi_cmp_w(input int short_w);
        return short_w + 1;
    endfunction

    // G has two Bayer sites per 2x2 cell, so its accumulators get one extra
    // bit and the outputs drop the LSB (sum/2, count/2).
    function automatic int acc_w(input int base_w, input int ch);
        return (ch == CH_G) ? base_w + 1 : base_w;
    endfunction

endpackage

// File: rtl/wb_statis_roi_win.sv
// Row/column position tracking and ROI window decode. ROI registers are
// shadowed at frame start so mid-frame register writes do not tear a frame.
module wb_statis_roi_win
    import wb_statis_roi_pkg::*;
#(
    parameter int SHORT_REG_WD = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_fval,
    input  logic                    i_lval,
    input  logic                    i_fval_rise,
    input  logic [SHORT_REG_WD-1:0] iv_roi_offset_x,
    input  logic [SHORT_REG_WD-1:0] iv_roi_offset_y,
    input  logic [SHORT_REG_WD-1:0] iv_roi_width,
    input  logic [SHORT_REG_WD-1:0] iv_roi_height,
    output logic                    o_in_roi
);

    localparam int CW = roi_cmp_w(SHORT_REG_WD);

    logic [CW-1:0]           col_q, col_d, row_q, row_d;
    logic                    lval_dly_q, lval_dly_d;
    logic [SHORT_REG_WD-1:0] ox_q, ox_d, oy_q, oy_d, w_q, w_d, h_q, h_d;
    logic [CW-1:0]           x_end, y_end;

    // Counters saturate rather than wrap so an over-long line never re-enters the ROI.
    always_comb begin
        lval_dly_d = i_lval;
        col_d      = col_q;
        row_d      = row_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        w_d        = w_q;
        h_d        = h_q;
        if (!i_lval)
            col_d = '0;
        else if (col_q != '1)
            col_d = col_q + CW'(1);
        if (i_fval_rise)
            row_d = '0;
        else if (lval_dly_q && !i_lval && i_fval && row_q != '1)
            row_d = row_q + CW'(1);
        if (i_fval_rise) begin
            ox_d = iv_roi_offset_x;
            oy_d = iv_roi_offset_y;
            w_d  = iv_roi_width;
            h_d  = iv_roi_height;
        end
    end

    // Position and shadow state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q      <= '0;
            row_q      <= '0;
            lval_dly_q <= 1'b0;
            ox_q       <= '0;
            oy_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            lval_dly_q <= lval_dly_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            w_q        <= w_d;
            h_q        <= h_d;
        end
    end

    // Window decode; zero width or height gives an empty window naturally.
    always_comb begin
        x_end    = {1'b0, ox_q} + {1'b0, w_q};
        y_end    = {1'b0, oy_q} + {1'b0, h_q};
        o_in_roi = (col_q >= {1'b0, ox_q}) && (col_q < x_end) &&
                   (row_q >= {1'b0, oy_q}) && (row_q < y_end);
    end

endmodule

// File: rtl/wb_statis_roi.sv
// White-balance statistics: saturating per-channel sums of an 8-bit pixel
// slice and pixel counts inside an ROI, latched to registers on interrupt.
module wb_statis_roi
    import wb_statis_roi_pkg::*;
#(
    parameter int SENSOR_DAT_WIDTH = 10,
    parameter int WB_STATIS_WIDTH  = 29,
    parameter int REG_WD           = 32,
    parameter int SHORT_REG_WD     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_fval,
    input  logic                        i_lval,
    input  logic [SENSOR_DAT_WIDTH-1:0] iv_pix_data,
    input  logic                        i_r_flag,
    input  logic                        i_g_flag,
    input  logic                        i_b_flag,
    input  logic                        i_interrupt_pin,
    input  logic                        i_wb_statis_en,
    input  logic [3:0]                  iv_bit_shift,
    input  logic [SHORT_REG_WD-1:0]     iv_roi_offset_x,
    input  logic [SHORT_REG_WD-1:0]     iv_roi_offset_y,
    input  logic [SHORT_REG_WD-1:0]     iv_roi_width,
    input  logic [SHORT_REG_WD-1:0]     iv_roi_height,
    output logic [WB_STATIS_WIDTH-1:0]  ov_wb_statis_r,
    output logic [WB_STATIS_WIDTH-1:0]  ov_wb_statis_g,
    output logic [WB_STATIS_WIDTH-1:0]  ov_wb_statis_b,
    output logic [REG_WD-1:0]           ov_wb_cnt_r,
    output logic [REG_WD-1:0]           ov_wb_cnt_g,
    output logic [REG_WD-1:0]           ov_wb_cnt_b,
    output logic                        o_statis_ovf,
    output logic                        o_statis_valid
);

    localparam logic [3:0] MAX_SHIFT = 4'(max_shift(SENSOR_DAT_WIDTH));

    logic                  fval_dly_q, fval_dly_d, int_dly_q, int_dly_d;
    logic                  fval_rise, int_rise;
    logic                  en_q, en_d;
    logic [3:0]            shift_q, shift_d;
    logic                  ovf_q, ovf_d, ovf_lat_q, ovf_lat_d;
    logic                  valid_q, valid_d;
    logic                  in_roi;
    logic [SLICE_W-1:0]    slice;
    logic [NUM_CH-1:0]     flag, ch_ovf;
    logic [NUM_CH-1:0][WB_STATIS_WIDTH-1:0] sum_lat;
    logic [NUM_CH-1:0][REG_WD-1:0]          cnt_lat;

    wb_statis_roi_win #(.SHORT_REG_WD(SHORT_REG_WD)) u_win (
        .clk             (clk),
        .reset           (reset),
        .i_fval          (i_fval),
        .i_lval          (i_lval),
        .i_fval_rise     (fval_rise),
        .iv_roi_offset_x (iv_roi_offset_x),
        .iv_roi_offset_y (iv_roi_offset_y),
        .iv_roi_width    (iv_roi_width),
        .iv_roi_height   (iv_roi_height),
        .o_in_roi        (in_roi)
    );

    // Edge detects, frame-start shadows, sticky overflow and latch strobe.
    always_comb begin
        fval_dly_d = i_fval;
        int_dly_d  = i_interrupt_pin;
        fval_rise  = !fval_dly_q && i_fval;
        int_rise   = !int_dly_q && i_interrupt_pin;
        en_d       = en_q;
        shift_d    = shift_q;
        if (fval_rise) begin
            en_d    = i_wb_statis_en;
            shift_d = (iv_bit_shift > MAX_SHIFT) ? MAX_SHIFT : iv_bit_shift;
        end
        ovf_d     = fval_rise ? 1'b0 : (ovf_q || (|ch_ovf));
        ovf_lat_d = int_rise ? ovf_q : ovf_lat_q;
        valid_d   = int_rise;
        slice     = SLICE_W'(iv_pix_data >> shift_q);
        flag      = {i_b_flag, i_g_flag, i_r_flag};
    end

    // Control state; edge-detect delays reset high so a level already high
    // at reset release is not seen as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fval_dly_q <= 1'b1;
            int_dly_q  <= 1'b1;
            en_q       <= 1'b0;
            shift_q    <= '0;
            ovf_q      <= 1'b0;
            ovf_lat_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            fval_dly_q <= fval_dly_d;
            int_dly_q  <= int_dly_d;
            en_q       <= en_d;
            shift_q    <= shift_d;
            ovf_q      <= ovf_d;
            ovf_lat_q  <= ovf_lat_d;
            valid_q    <= valid_d;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        localparam int AW  = acc_w(WB_STATIS_WIDTH, ch);
        localparam int CNW = acc_w(REG_WD, ch);

        logic [AW-1:0]              acc_q, acc_d;
        logic [CNW-1:0]             cnt_q, cnt_d;
        logic [AW:0]                acc_sum;
        logic [CNW:0]               cnt_sum;
        logic [WB_STATIS_WIDTH-1:0] sum_lat_q, sum_lat_d;
        logic [REG_WD-1:0]          cnt_lat_q, cnt_lat_d;
        logic                       ovf_hit;

        // Saturating accumulate; frame start clear wins over a coincident pixel.
        always_comb begin
            acc_sum   = {1'b0, acc_q} + {{(AW + 1 - SLICE_W){1'b0}}, slice};
            cnt_sum   = {1'b0, cnt_q} + (CNW + 1)'(1);
            acc_d     = acc_q;
            cnt_d     = cnt_q;
            ovf_hit   = 1'b0;
            if (fval_rise) begin
                acc_d = '0;
                cnt_d = '0;
            end else if (en_q && in_roi && flag[ch]) begin
                if (acc_sum[AW]) begin
                    acc_d   = '1;
                    ovf_hit = 1'b1;
                end else begin
                    acc_d = acc_sum[AW-1:0];
                end
                if (cnt_sum[CNW]) begin
                    cnt_d   = '1;
                    ovf_hit = 1'b1;
                end else begin
                    cnt_d = cnt_sum[CNW-1:0];
                end
            end
            sum_lat_d = sum_lat_q;
            cnt_lat_d = cnt_lat_q;
            if (int_rise) begin
                sum_lat_d = acc_q[AW-1 -: WB_STATIS_WIDTH];
                cnt_lat_d = cnt_q[CNW-1 -: REG_WD];
            end
        end

        // Accumulators and register-side latches.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                acc_q     <= '0;
                cnt_q     <= '0;
                sum_lat_q <= '0;
                cnt_lat_q <= '0;
            end else begin
                acc_q     <= acc_d;
                cnt_q     <= cnt_d;
                sum_lat_q <= sum_lat_d;
                cnt_lat_q <= cnt_lat_d;
            end
        end

        assign ch_ovf[ch]  = ovf_hit;
        assign sum_lat[ch] = sum_lat_q;
        assign cnt_lat[ch] = cnt_lat_q;
    end

    assign ov_wb_statis_r = sum_lat[0];
    assign ov_wb_statis_g = sum_lat[1];
    assign ov_wb_statis_b = sum_lat[2];
    assign ov_wb_cnt_r    = cnt_lat[0];
    assign ov_wb_cnt_g    = cnt_lat[1];
    assign ov_wb_cnt_b    = cnt_lat[2];
    assign o_statis_ovf   = ovf_lat_q;
    assign o_statis_valid = valid_q;

endmodule

// File: tb/tb_wb_statis_roi.sv
// Directed bench for wb_statis_roi: default-width instance plus a 9-bit-sum
// instance sharing the same stimulus for the saturation case.
module tb_wb_statis_roi;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_fval = 1'b0, i_lval = 1'b0;
    logic [9:0]  iv_pix_data = '0;
    logic        i_r_flag = 1'b0, i_g_flag = 1'b0, i_b_flag = 1'b0;
    logic        i_interrupt_pin = 1'b0, i_wb_statis_en = 1'b0;
    logic [3:0]  iv_bit_shift = '0;
    logic [15:0] ox = '0, oy = '0, rw = '0, rh = '0;

    logic [28:0] sr, sg, sb;
    logic [31:0] cr, cg, cb;
    logic        ovf, vld;
    logic [8:0]  sr9, sg9, sb9;
    logic [31:0] cr9, cg9, cb9;
    logic        ovf9, vld9;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_statis_roi dut (
        .clk(clk), .reset(reset), .i_fval(i_fval), .i_lval(i_lval),
        .iv_pix_data(iv_pix_data), .i_r_flag(i_r_flag), .i_g_flag(i_g_flag),
        .i_b_flag(i_b_flag), .i_interrupt_pin(i_interrupt_pin),
        .i_wb_statis_en(i_wb_statis_en), .iv_bit_shift(iv_bit_shift),
        .iv_roi_offset_x(ox), .iv_roi_offset_y(oy), .iv_roi_width(rw),
        .iv_roi_height(rh), .ov_wb_statis_r(sr), .ov_wb_statis_g(sg),
        .ov_wb_statis_b(sb), .ov_wb_cnt_r(cr), .ov_wb_cnt_g(cg), .ov_wb_cnt_b(cb),
        .o_statis_ovf(ovf), .o_statis_valid(vld)
    );

    wb_statis_roi #(.WB_STATIS_WIDTH(9)) dut9 (
        .clk(clk), .reset(reset), .i_fval(i_fval), .i_lval(i_lval),
        .iv_pix_data(iv_pix_data), .i_r_flag(i_r_flag), .i_g_flag(i_g_flag),
        .i_b_flag(i_b_flag), .i_interrupt_pin(i_interrupt_pin),
        .i_wb_statis_en(i_wb_statis_en), .iv_bit_shift(iv_bit_shift),
        .iv_roi_offset_x(ox), .iv_roi_offset_y(oy), .iv_roi_width(rw),
        .iv_roi_height(rh), .ov_wb_statis_r(sr9), .ov_wb_statis_g(sg9),
        .ov_wb_statis_b(sb9), .ov_wb_cnt_r(cr9), .ov_wb_cnt_g(cg9), .ov_wb_cnt_b(cb9),
        .o_statis_ovf(ovf9), .o_statis_valid(vld9)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic en, input logic [3:0] sh, input int x, input int y,
                       input int w, input int h);
        i_wb_statis_en = en;
        iv_bit_shift   = sh;
        ox = 16'(x); oy = 16'(y); rw = 16'(w); rh = 16'(h);
    endtask

    // mode 0: every pixel = cval; mode 1: pixel = row*16 + col. RGGB Bayer.
    task automatic send_frame(input int rows, input int cols, input int mode,
                              input logic [9:0] cval);
        i_fval = 1'b1;
        tick(2);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                i_lval      = 1'b1;
                iv_pix_data = (mode == 1) ? 10'(r * 16 + c) : cval;
                i_r_flag    = (r % 2 == 0) && (c % 2 == 0);
                i_g_flag    = ((r + c) % 2 == 1);
                i_b_flag    = (r % 2 == 1) && (c % 2 == 1);
                tick();
            end
            i_lval = 1'b0;
            i_r_flag = 1'b0; i_g_flag = 1'b0; i_b_flag = 1'b0;
            tick(2);
        end
        i_fval = 1'b0;
        tick(2);
    endtask

    task automatic chk_out(input string p, input int er, input int eg, input int eb,
                           input int ecr, input int ecg, input int ecb, input logic eovf);
        chk({p, ".sum_r"}, 64'(sr), 64'(er));
        chk({p, ".sum_g"}, 64'(sg), 64'(eg));
        chk({p, ".sum_b"}, 64'(sb), 64'(eb));
        chk({p, ".cnt_r"}, 64'(cr), 64'(ecr));
        chk({p, ".cnt_g"}, 64'(cg), 64'(ecg));
        chk({p, ".cnt_b"}, 64'(cb), 64'(ecb));
        chk({p, ".ovf"},   64'(ovf), 64'(eovf));
    endtask

    // Interrupt pulse; results and the valid pulse appear one cycle later.
    task automatic latch_chk(input string p, input int er, input int eg, input int eb,
                             input int ecr, input int ecg, input int ecb, input logic eovf);
        i_interrupt_pin = 1'b1;
        tick();
        i_interrupt_pin = 1'b0;
        chk({p, ".valid"}, 64'(vld), 64'd1);
        chk_out(p, er, eg, eb, ecr, ecg, ecb, eovf);
        tick();
        chk({p, ".valid_end"}, 64'(vld), 64'd0);
    endtask

    initial begin
        tick(3);
        chk_out("reset", 0, 0, 0, 0, 0, 0, 1'b0);
        chk("reset.valid", 64'(vld), 64'd0);
        reset = 1'b0;
        tick(2);

        // Full-frame 4x2, 0x3FC >> 2 = 255 per pixel; 2 R, 4 G, 2 B.
        cfg(1'b1, 4'd2, 0, 0, 4, 2);
        send_frame(2, 4, 0, 10'h3FC);
        latch_chk("full", 510, 510, 510, 2, 2, 2, 1'b0);

        // Slice select on a single R pixel, 1x1 ROI.
        cfg(1'b1, 4'd0, 0, 0, 1, 1);
        send_frame(1, 1, 0, 10'h155);
        latch_chk("sh0_155", 'h55, 0, 0, 1, 0, 0, 1'b0);
        cfg(1'b1, 4'd2, 0, 0, 1, 1);
        send_frame(1, 1, 0, 10'h155);
        latch_chk("sh2_155", 'h55, 0, 0, 1, 0, 0, 1'b0);
        cfg(1'b1, 4'd0, 0, 0, 1, 1);
        send_frame(1, 1, 0, 10'h3F0);
        latch_chk("sh0_3f0", 'hF0, 0, 0, 1, 0, 0, 1'b0);
        cfg(1'b1, 4'd2, 0, 0, 1, 1);
        send_frame(1, 1, 0, 10'h3F0);
        latch_chk("sh2_3f0", 'hFC, 0, 0, 1, 0, 0, 1'b0);
        cfg(1'b1, 4'd7, 0, 0, 1, 1);
        send_frame(1, 1, 0, 10'h3F0);
        latch_chk("sh7_clamp", 'hFC, 0, 0, 1, 0, 0, 1'b0);

        // ROI (2,1,2,1) on 8x4: only G@(1,2)=18 and B@(1,3)=19.
        cfg(1'b1, 4'd0, 2, 1, 2, 1);
        send_frame(4, 8, 1, 10'h000);
        latch_chk("roi", 0, 9, 19, 0, 0, 1, 1'b0);

        // Empty ROI (width 0).
        cfg(1'b1, 4'd0, 0, 0, 0, 4);
        send_frame(2, 4, 0, 10'h0FF);
        latch_chk("empty", 0, 0, 0, 0, 0, 0, 1'b0);

        // Saturation: 3 R of 255 into a 9-bit sum saturates at 511.
        cfg(1'b1, 4'd0, 0, 0, 5, 1);
        send_frame(1, 5, 0, 10'h0FF);
        latch_chk("wide", 765, 255, 0, 3, 1, 0, 1'b0);
        chk("sat.sum_r", 64'(sr9), 64'd511);
        chk("sat.cnt_r", 64'(cr9), 64'd3);
        chk("sat.ovf",   64'(ovf9), 64'd1);
        cfg(1'b1, 4'd0, 0, 0, 1, 1);
        send_frame(1, 1, 0, 10'h000);
        latch_chk("after_sat", 0, 0, 0, 1, 0, 0, 1'b0);
        chk("sat_clr.ovf",   64'(ovf9), 64'd0);
        chk("sat_clr.sum_r", 64'(sr9), 64'd0);

        // Interrupt coincident with frame start captures pre-clear sums.
        cfg(1'b1, 4'd0, 0, 0, 1, 1);
        send_frame(1, 1, 0, 10'd100);
        i_fval = 1'b1;
        i_interrupt_pin = 1'b1;
        tick();
        i_interrupt_pin = 1'b0;
        chk("coinc.valid", 64'(vld), 64'd1);
        chk("coinc.sum_r", 64'(sr), 64'd100);
        chk("coinc.cnt_r", 64'(cr), 64'd1);
        tick(2);
        i_fval = 1'b0;
        tick(2);
        latch_chk("coinc_clr", 0, 0, 0, 0, 0, 0, 1'b0);

        // Async reset mid-line with nonzero outputs.
        cfg(1'b1, 4'd2, 0, 0, 4, 2);
        send_frame(2, 4, 0, 10'h3FC);
        latch_chk("pre_rst", 510, 510, 510, 2, 2, 2, 1'b0);
        i_fval = 1'b1;
        tick(2);
        i_lval = 1'b1; i_r_flag = 1'b1; iv_pix_data = 10'h3FC;
        tick(2);
        reset = 1'b1;
        #1;
        chk_out("rst_mid", 0, 0, 0, 0, 0, 0, 1'b0);
        chk("rst_mid.valid", 64'(vld), 64'd0);
        i_interrupt_pin = 1'b1;
        i_lval = 1'b0; i_r_flag = 1'b0;
        tick(2);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_rel.valid", 64'(vld), 64'd0);
        end
        chk_out("rst_rel", 0, 0, 0, 0, 0, 0, 1'b0);
        i_interrupt_pin = 1'b0;
        i_fval = 1'b0;
        tick(2);

        // Disabled frame accumulates nothing; then a fresh enabled frame.
        cfg(1'b0, 4'd2, 0, 0, 4, 2);
        send_frame(2, 4, 0, 10'h3FC);
        latch_chk("en0", 0, 0, 0, 0, 0, 0, 1'b0);
        cfg(1'b1, 4'd2, 0, 0, 4, 2);
        send_frame(2, 4, 0, 10'h3FC);
        latch_chk("fresh", 510, 510, 510, 2, 2, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
